// File: rtl/axi_burst_mem_slave.sv
// AXI4 burst responder backed by a word-addressed array, one burst per channel.
// Define AXI_MEM_WAIT_EN to add WAIT_CYCLES before the first R beat and bvalid.
module axi_burst_mem_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;

    logic [31:0] mem_q [DEPTH];

    r_state_e          r_state_q, r_state_d;
    logic [ADDR_W-1:0] r_idx_q, r_idx_d, r_next_idx;
    logic [7:0]        r_len_q, r_len_d;
    logic [7:0]        r_cnt_q, r_cnt_d;
    logic              r_fixed_q, r_fixed_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              rlast_q, rlast_d;

    w_state_e          w_state_q, w_state_d;
    logic [ADDR_W-1:0] w_idx_q, w_idx_d;
    logic [7:0]        w_len_q, w_len_d;
    logic [7:0]        w_cnt_q, w_cnt_d;
    logic              w_fixed_q, w_fixed_d;
    logic              w_err_q, w_err_d;
    logic              mem_we;

`ifdef AXI_MEM_WAIT_EN
    logic [7:0] r_wait_q, r_wait_d;
    logic [7:0] w_wait_q, w_wait_d;
`endif

    logic [ADDR_W-1:0] ar_idx, aw_idx;
    logic              unused;

    assign ar_idx = araddr[ADDR_W+1:2];
    assign aw_idx = awaddr[ADDR_W+1:2];
    assign unused = ^{araddr[31:ADDR_W+2], araddr[1:0],
                      awaddr[31:ADDR_W+2], awaddr[1:0],
                      arsize, awsize, WAIT_CYCLES == 0};

    assign arready = (r_state_q == R_IDLE);
    assign rvalid  = (r_state_q == R_DATA);
    assign rdata   = rdata_q;
    assign rlast   = rlast_q;
    assign rresp   = 2'b00;

    assign awready = (w_state_q == W_IDLE);
    assign wready  = (w_state_q == W_DATA);
    assign bvalid  = (w_state_q == W_RESP);
    assign bresp   = (bvalid && w_err_q) ? 2'b10 : 2'b00;

    assign r_next_idx = r_fixed_q ? r_idx_q : r_idx_q + ADDR_W'(1);
    assign mem_we     = (w_state_q == W_DATA) && wvalid;

    // Array has no reset; the read port samples old data on a same-cycle write.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem_q[w_idx_q][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_idx_d   = r_idx_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_fixed_d = r_fixed_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
`ifdef AXI_MEM_WAIT_EN
        r_wait_d  = r_wait_q;
`endif
        unique case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    r_idx_d   = ar_idx;
                    r_len_d   = arlen;
                    r_cnt_d   = 8'd0;
                    r_fixed_d = (arburst == 2'b00);
`ifdef AXI_MEM_WAIT_EN
                    r_wait_d  = 8'd0;
                    r_state_d = R_WAIT;
`else
                    rdata_d   = mem_q[ar_idx];
                    rlast_d   = (arlen == 8'd0);
                    r_state_d = R_DATA;
`endif
                end
            end
`ifdef AXI_MEM_WAIT_EN
            R_WAIT: begin
                if (r_wait_q == 8'(WAIT_CYCLES - 1)) begin
                    rdata_d   = mem_q[r_idx_q];
                    rlast_d   = (r_len_q == 8'd0);
                    r_state_d = R_DATA;
                end else begin
                    r_wait_d = r_wait_q + 8'd1;
                end
            end
`endif
            R_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        r_idx_d = r_next_idx;
                        r_cnt_d = r_cnt_q + 8'd1;
                        rdata_d = mem_q[r_next_idx];
                        rlast_d = (r_cnt_q + 8'd1 == r_len_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_fixed_q <= 1'b0;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
`ifdef AXI_MEM_WAIT_EN
            r_wait_q  <= '0;
`endif
        end else begin
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_fixed_q <= r_fixed_d;
            rdata_q   <= rdata_d;
            rlast_q   <= rlast_d;
`ifdef AXI_MEM_WAIT_EN
            r_wait_q  <= r_wait_d;
`endif
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_fixed_d = w_fixed_q;
        w_err_d   = w_err_q;
`ifdef AXI_MEM_WAIT_EN
        w_wait_d  = w_wait_q;
`endif
        unique case (w_state_q)
            W_IDLE: begin
                if (awvalid) begin
                    w_idx_d   = aw_idx;
                    w_len_d   = awlen;
                    w_cnt_d   = 8'd0;
                    w_fixed_d = (awburst == 2'b00);
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wvalid) begin
                    w_idx_d = w_fixed_q ? w_idx_q : w_idx_q + ADDR_W'(1);
                    w_cnt_d = w_cnt_q + 8'd1;
                    // Early wlast, or the len beat without wlast (overrun).
                    if (wlast != (w_cnt_q == w_len_q)) w_err_d = 1'b1;
                    if (wlast) begin
`ifdef AXI_MEM_WAIT_EN
                        w_wait_d  = 8'd0;
                        w_state_d = W_WAIT;
`else
                        w_state_d = W_RESP;
`endif
                    end
                end
            end
`ifdef AXI_MEM_WAIT_EN
            W_WAIT: begin
                if (w_wait_q == 8'(WAIT_CYCLES - 1)) w_state_d = W_RESP;
                else w_wait_d = w_wait_q + 8'd1;
            end
`endif
            W_RESP: begin
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_fixed_q <= 1'b0;
            w_err_q   <= 1'b0;
`ifdef AXI_MEM_WAIT_EN
            w_wait_q  <= '0;
`endif
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_fixed_q <= w_fixed_d;
            w_err_q   <= w_err_d;
`ifdef AXI_MEM_WAIT_EN
            w_wait_q  <= w_wait_d;
`endif
        end
    end

endmodule

// File: tb/tb_axi_burst_mem_slave.sv
// Directed self-checking bench for axi_burst_mem_slave.
// Inputs change and outputs are sampled on the falling edge.
module tb_axi_burst_mem_slave;

`ifdef AXI_MEM_WAIT_EN
    localparam int RLAT = 3;
`else
    localparam int RLAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr = '0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = 3'b010;
    logic [1:0]  arburst = 2'b01;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [31:0] awaddr = '0;
    logic [7:0]  awlen = '0;
    logic [2:0]  awsize = 3'b010;
    logic [1:0]  awburst = 2'b01;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;

    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] ev [8];

    axi_burst_mem_slave dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
        .awburst(awburst), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic aw_hs(input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] bt);
        int n;
        @(negedge clk);
        awaddr = a; awlen = len; awburst = bt; awvalid = 1'b1;
        n = 0;
        while (!awready && n < 20) begin @(negedge clk); n++; end
        chk("awready", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] s,
                          input logic last);
        int n;
        @(negedge clk);
        wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
        n = 0;
        while (!wready && n < 20) begin @(negedge clk); n++; end
        chk("wready", 32'(wready), 32'd1);
        @(posedge clk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_wait(input string tag, input logic [1:0] exp);
        int n;
        @(negedge clk);
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        chk({tag, "_bvalid"}, 32'(bvalid), 32'd1);
        chk({tag, "_bresp"}, 32'(bresp), 32'(exp));
        @(posedge clk); #1;
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
        aw_hs(a, 8'd0, 2'b01);
        w_beat(d, s, 1'b1);
        b_wait("wr1", 2'b00);
    endtask

    task automatic ar_hs(input logic [31:0] a, input logic [7:0] len,
                         input logic [1:0] bt);
        int n;
        @(negedge clk);
        araddr = a; arlen = len; arburst = bt; arvalid = 1'b1;
        n = 0;
        while (!arready && n < 20) begin @(negedge clk); n++; end
        chk("arready", 32'(arready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0;
    endtask

    // Expects n beats from ev[] at full throughput after an AR handshake.
    task automatic rd_expect(input string tag, input int n);
        int lat;
        rready = 1'b1;
        lat = 1;
        @(negedge clk);
        while (!rvalid && lat < 20) begin @(negedge clk); lat++; end
        chk({tag, "_lat"}, lat, RLAT);
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
            chk({tag, "_rdata"}, rdata, ev[i]);
            chk({tag, "_rlast"}, 32'(rlast), 32'(i == n - 1));
            chk({tag, "_rresp"}, 32'(rresp), 32'd0);
        end
        @(negedge clk);
        chk({tag, "_done"}, 32'(rvalid), 32'd0);
    endtask

    initial begin
        // Reset values, during and just after reset
        @(negedge clk);
        chk("rst_arready", 32'(arready), 32'd1);
        chk("rst_awready", 32'(awready), 32'd1);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_rlast", 32'(rlast), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_rresp", 32'(rresp), 32'd0);
        chk("rst_wready", 32'(wready), 32'd0);
        chk("rst_bvalid", 32'(bvalid), 32'd0);
        chk("rst_bresp", 32'(bresp), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_arready", 32'(arready), 32'd1);
        chk("post_rst_rvalid", 32'(rvalid), 32'd0);

        // Single word write then read
        wr1(32'h10, 32'hDEADBEEF, 4'hF);
        ar_hs(32'h10, 8'd0, 2'b01);
        ev[0] = 32'hDEADBEEF;
        rd_expect("single", 1);

        // 4-beat INCR burst
        aw_hs(32'h100, 8'd3, 2'b01);
        w_beat(32'd1, 4'hF, 1'b0);
        w_beat(32'd2, 4'hF, 1'b0);
        w_beat(32'd3, 4'hF, 1'b0);
        w_beat(32'd4, 4'hF, 1'b1);
        b_wait("incr", 2'b00);
        ar_hs(32'h100, 8'd3, 2'b01);
        ev[0] = 32'd1; ev[1] = 32'd2; ev[2] = 32'd3; ev[3] = 32'd4;
        rd_expect("incr", 4);

        // Read backpressure: beat 2 held for two stalled cycles
        ar_hs(32'h100, 8'd3, 2'b01);
        for (int i = 0; i < RLAT; i++) @(negedge clk);
        rready = 1'b1;
        chk("bp_b1", rdata, 32'd1);
        @(negedge clk); rready = 1'b0;
        chk("bp_b2_data0", rdata, 32'd2);
        @(negedge clk);
        chk("bp_b2_data1", rdata, 32'd2);
        chk("bp_b2_valid1", 32'(rvalid), 32'd1);
        chk("bp_b2_last1", 32'(rlast), 32'd0);
        @(negedge clk); rready = 1'b1;
        chk("bp_b2_data2", rdata, 32'd2);
        @(negedge clk);
        chk("bp_b3", rdata, 32'd3);
        @(negedge clk); rready = 1'b0;
        chk("bp_b4_data", rdata, 32'd4);
        chk("bp_b4_last", 32'(rlast), 32'd1);
        @(negedge clk); rready = 1'b1;
        chk("bp_b4_hold", rdata, 32'd4);
        chk("bp_b4_hold_last", 32'(rlast), 32'd1);
        @(negedge clk);
        chk("bp_done", 32'(rvalid), 32'd0);

        // Early wlast: awlen=3, wlast on beat 2
        aw_hs(32'h300, 8'd3, 2'b01);
        w_beat(32'h31, 4'hF, 1'b0);
        w_beat(32'h32, 4'hF, 1'b1);
        b_wait("early", 2'b10);
        // Overrun: awlen=0 with two beats, both still written
        aw_hs(32'h310, 8'd0, 2'b01);
        w_beat(32'h41, 4'hF, 1'b0);
        w_beat(32'h42, 4'hF, 1'b1);
        b_wait("overrun", 2'b10);
        ar_hs(32'h310, 8'd1, 2'b01);
        ev[0] = 32'h41; ev[1] = 32'h42;
        rd_expect("overrun_rd", 2);

        // Byte strobes (also shows the error flag clears)
        wr1(32'h200, 32'h11223344, 4'hF);
        wr1(32'h200, 32'hAABBCCDD, 4'b0101);
        ar_hs(32'h200, 8'd0, 2'b01);
        ev[0] = 32'h11BB33DD;
        rd_expect("strb", 1);

        // FIXED write and read
        aw_hs(32'h40, 8'd1, 2'b00);
        w_beat(32'h55, 4'hF, 1'b0);
        w_beat(32'h66, 4'hF, 1'b1);
        b_wait("fixed", 2'b00);
        ar_hs(32'h40, 8'd1, 2'b00);
        ev[0] = 32'h66; ev[1] = 32'h66;
        rd_expect("fixed_rd", 2);

        // Index wrap 1023 -> 0, and upper address bits ignored
        wr1(32'hFFC, 32'hA1, 4'hF);
        wr1(32'h0, 32'hB0, 4'hF);
        ar_hs(32'hFFC, 8'd1, 2'b01);
        ev[0] = 32'hA1; ev[1] = 32'hB0;
        rd_expect("wrap", 2);
        ar_hs(32'h1010, 8'd0, 2'b01);
        ev[0] = 32'hDEADBEEF;
        rd_expect("alias", 1);

        // Same-cycle AR handshake and W beat to word 0x10
        aw_hs(32'h10, 8'd0, 2'b01);
        @(negedge clk);
        araddr = 32'h10; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
        wdata = 32'hCAFEF00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
        chk("rbw_arready", 32'(arready), 32'd1);
        chk("rbw_wready", 32'(wready), 32'd1);
        @(posedge clk); #1;
        arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        ev[0] = 32'hDEADBEEF;
        rd_expect("rbw_old", 1);
        ar_hs(32'h10, 8'd0, 2'b01);
        ev[0] = 32'hCAFEF00D;
        rd_expect("rbw_new", 1);

        // Reset during beat 2 of an 8-beat read
        ar_hs(32'h100, 8'd7, 2'b01);
        for (int i = 0; i < RLAT; i++) @(negedge clk);
        chk("mid_b1", rdata, 32'd1);
        @(negedge clk);
        chk("mid_b2", rdata, 32'd2);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rvalid", 32'(rvalid), 32'd0);
        chk("mid_arready", 32'(arready), 32'd1);
        chk("mid_awready", 32'(awready), 32'd1);
        chk("mid_rlast", 32'(rlast), 32'd0);
        rst = 1'b0;
        ar_hs(32'h104, 8'd0, 2'b01);
        ev[0] = 32'd2;
        rd_expect("after_rst", 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
